// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, N_BITS x N_BITS -> 2*N_BITS.
// One multiplier bit is consumed per clock. Signed operands are reduced to
// magnitudes on entry and the product sign is restored on the final step.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operands present
//   o_in_ready   block can accept operands (IDLE only)
//   i_a, i_b     multiplicand / multiplier
//   i_signed     1 = two's-complement operands, sampled with operands
//   o_out_valid  o_mult holds a finished product
//   i_out_ready  consumer accepts the product
//   o_mult       product (held until the next completed operation)
//   o_busy       high while multiplying
//
// Optional build macro: SEQ_MULT_EARLY_TERM_EN
//   When defined, finishes as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
    parameter int N_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [N_BITS-1:0]     i_a,
    input  logic [N_BITS-1:0]     i_b,
    input  logic                  i_signed,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [2*N_BITS-1:0]   o_mult,
    output logic                  o_busy
);

    localparam int STEP_W = $clog2(N_BITS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [2*N_BITS-1:0]   mcand;
    logic [2*N_BITS-1:0]   acc;
    logic [2*N_BITS-1:0]   acc_sum;
    logic [N_BITS-1:0]     mplier;
    logic [N_BITS-1:0]     mplier_shr;
    logic [N_BITS-1:0]     mag_a;
    logic [N_BITS-1:0]     mag_b;
    logic [STEP_W-1:0]     step;
    logic                  neg;
    logic                  last_step;

    always_comb begin
        o_in_ready = (state == IDLE) && i_rst_n;
        // |-2^(N-1)| = 2^(N-1) still fits the unsigned N-bit magnitude.
        mag_a      = (i_signed && i_a[N_BITS-1]) ? -i_a : i_a;
        mag_b      = (i_signed && i_b[N_BITS-1]) ? -i_b : i_b;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        mplier_shr = mplier >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_step  = (step == STEP_W'(N_BITS - 1)) || (mplier_shr == '0);
`else
        last_step  = (step == STEP_W'(N_BITS - 1));
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            step        <= '0;
            neg         <= 1'b0;
            o_mult      <= '0;
            o_out_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // o_in_ready is 1 here, so i_in_valid alone is the handshake.
                    if (i_in_valid) begin
                        mcand  <= {{N_BITS{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= i_signed & (i_a[N_BITS-1] ^ i_b[N_BITS-1]);
                        acc    <= '0;
                        step   <= '0;
                        o_busy <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mplier <= mplier_shr;
                    mcand  <= mcand << 1;
                    step   <= step + STEP_W'(1);
                    if (last_step) begin
                        // Negating a zero sum yields zero, so 0 is never signed.
                        o_mult      <= neg ? -acc_sum : acc_sum;
                        o_out_valid <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N_BITS = 8): directed vector table,
// backpressure, mid-run reset, back-to-back and randomized operations checked
// against an arithmetic reference model.
module tb_seq_multiplier;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sgn;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] mult;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    seq_multiplier #(.N_BITS(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_signed    (sgn),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_mult      (mult),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference product from plain integer arithmetic.
    function automatic logic [2*N-1:0] ref_prod(logic [N-1:0] x, logic [N-1:0] y, logic s);
        longint      xs;
        longint      ys;
        logic [63:0] r;
        if (s) begin
            xs = longint'($signed(x));
            ys = longint'($signed(y));
        end else begin
            xs = longint'(x);
            ys = longint'(y);
        end
        r = xs * ys;
        return r[2*N-1:0];
    endfunction

    // Expected edges from input handshake to out_valid.
    function automatic int exp_lat(logic [N-1:0] y, logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [N-1:0] m;
        int           hi;
        m  = (s && y[N-1]) ? -y : y;
        hi = 0;
        for (int i = 0; i < N; i++) if (m[i]) hi = i + 1;
        return (hi < 1) ? 1 : hi;
`else
        if (s) return N;
        return N;
`endif
    endfunction

    // Starts one operation and waits for the product; leaves out_ready low.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                          output logic [2*N-1:0] p, output int lat, output int busy_cnt,
                          output int rdy_seen);
        int w;
        a = x; b = y; sgn = s; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) check("in_ready_wait_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); sgn = 1'($urandom);
        lat = 0; busy_cnt = 0; rdy_seen = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        p = mult;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   x;
        logic [N-1:0]   y;
        logic           s;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [2*N-1:0] p;
        logic [2*N-1:0] held;
        int             lat;
        int             bc;
        int             rs;
        logic [N-1:0]   bx[3];
        logic [N-1:0]   by[3];
        logic           bs[3];
        int             out_cyc[3];
        int             idx;
        int             outs;
        int             cyc;
        logic           hs;
        logic           ov;
        logic [2*N-1:0] pm;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
        vecs[2] = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5] = '{8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[6] = '{8'h37, 8'h01, 1'b0, 16'h0037};
        vecs[7] = '{8'h37, 8'h00, 1'b0, 16'h0000};
        vecs[8] = '{8'h37, 8'h80, 1'b0, 16'h1B80};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_mult", 64'(mult), 0);
        check("reset_busy", 64'(busy), 0);
        check("reset_in_ready", 64'(in_ready), 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_reset_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].s, p, lat, bc, rs);
            check($sformatf("vec%0d_prod", i), 64'(p), 64'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].y, vecs[i].s)));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(lat));
            check($sformatf("vec%0d_ready_in_run", i), 64'(rs), 0);
            release_out();
        end

        // Backpressure: product held, new operands ignored
        run_op(8'h5A, 8'hC3, 1'b0, p, lat, bc, rs);
        held = p;
        check("bp_prod", 64'(p), 64'(ref_prod(8'h5A, 8'hC3, 1'b0)));
        for (int k = 0; k < 5; k++) begin
            a = 8'h11 + 8'(k); b = 8'h22; sgn = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_mult_stable", 64'(mult), 64'(held));
            check("bp_out_valid", 64'(out_valid), 1);
            check("bp_in_ready", 64'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out();
        check("bp_release_valid", 64'(out_valid), 0);
        check("bp_release_in_ready", 64'(in_ready), 1);
        check("bp_release_mult_kept", 64'(mult), 64'(held));
        check("bp_release_busy", 64'(busy), 0);

        // Reset in the middle of RUN
        a = 8'h37; b = 8'hD5; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_before_reset", 64'(busy), 1);
        rst_n = 1'b0; #1;
        check("mid_reset_out_valid", 64'(out_valid), 0);
        check("mid_reset_mult", 64'(mult), 0);
        check("mid_reset_busy", 64'(busy), 0);
        check("mid_reset_in_ready", 64'(in_ready), 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("mid_release_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;
        run_op(8'h03, 8'h05, 1'b0, p, lat, bc, rs);
        check("after_reset_prod", 64'(p), 64'h000F);
        check("after_reset_latency", 64'(lat), 64'(exp_lat(8'h05, 1'b0)));
        release_out();

        // Back-to-back with both handshakes held high
        bx[0] = 8'h12; by[0] = 8'h34; bs[0] = 1'b0;
        bx[1] = 8'hF0; by[1] = 8'h0F; bs[1] = 1'b1;
        bx[2] = 8'h81; by[2] = 8'hFE; bs[2] = 1'b1;
        idx = 0; outs = 0; cyc = 0;
        a = bx[0]; b = by[0]; sgn = bs[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (outs < 3 && cyc < 100) begin
            @(negedge clk);
            hs = in_ready && (idx < 3);
            ov = out_valid;
            pm = mult;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                idx++;
                if (idx < 3) begin
                    a = bx[idx]; b = by[idx]; sgn = bs[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov) begin
                check($sformatf("b2b%0d_prod", outs), 64'(pm), 64'(ref_prod(bx[outs], by[outs], bs[outs])));
                out_cyc[outs] = cyc;
                if (outs > 0)
                    check($sformatf("b2b%0d_spacing", outs), 64'(cyc - out_cyc[outs-1]),
                          64'(exp_lat(by[outs], bs[outs]) + 2));
                outs++;
            end
        end
        check("b2b_count", 64'(outs), 3);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Randomized operations against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] rx;
            logic [N-1:0] ry;
            logic         rsg;
            rx = N'($urandom); ry = N'($urandom); rsg = 1'($urandom);
            if (r % 8 == 0) ry = 8'h80;
            if (r % 8 == 1) rx = 8'h80;
            if (r % 8 == 2) ry = 8'h00;
            run_op(rx, ry, rsg, p, lat, bc, rs);
            check($sformatf("rand%0d_prod", r), 64'(p), 64'(ref_prod(rx, ry, rsg)));
            check($sformatf("rand%0d_latency", r), 64'(lat), 64'(exp_lat(ry, rsg)));
            release_out();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier: N_BITS x N_BITS operands, 2*N_BITS product.
- Processes one multiplier bit per clock, in place of a full combinational adder array, so area stays small as N_BITS grows.
- Adds a signed/unsigned mode and valid/ready handshakes on input and output.
- Sits between the operand source and the result consumer in the arithmetic datapath.

Parameters:
- N_BITS, 8, operand width; legal range >= 2. Product width is 2*N_BITS; step counter width is $clog2(N_BITS)+1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_in_valid  input  1  operands present
- o_in_ready  output  1  block can accept operands
- i_a  input  N_BITS  multiplicand
- i_b  input  N_BITS  multiplier
- i_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- o_out_valid  output  1  o_mult holds a finished product
- i_out_ready  input  1  consumer accepts the product
- o_mult  output  2*N_BITS  product
- o_busy  output  1  high in RUN

Behaviour:
- Reset: asynchronous on i_rst_n low, at any time including mid-operation.
  - State goes to IDLE.
  - o_in_ready=0 while reset is held. It rises combinationally from state once reset is released.
  - o_out_valid=0, o_mult=0, o_busy=0. All internal registers clear.
  - Any operation in flight is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_in_ready=1.
  - Input handshake is i_in_valid & o_in_ready at a rising edge.
  - On the handshake: latch i_signed and the operand magnitudes (|i_a|, |i_b| when signed, raw values otherwise), latch the result sign (sign(a) XOR sign(b) when signed, else 0), clear the accumulator, step=0, go to RUN.
- RUN:
  - o_in_ready=0, o_busy=1.
  - Each edge: if the current LSB of the multiplier shift register is 1, add the shifted multiplicand into the 2*N_BITS accumulator. Then shift the multiplier right, shift the multiplicand left, and increment step.
  - The edge that processes step N_BITS-1 goes to DONE.
  - On that same edge o_mult is loaded with the accumulator, two's-complement negated if the result sign is set, and o_out_valid is set.
- DONE:
  - o_out_valid=1; o_mult holds stable.
  - i_a, i_b, i_signed and i_in_valid are ignored.
  - Output handshake is o_out_valid & i_out_ready at an edge. On it: o_out_valid=0, go to IDLE, o_mult retains its value.
- Latency: N_BITS rising edges from the input handshake edge to o_out_valid high.
- Throughput: one operation per N_BITS+2 cycles with i_out_ready held high. No overlap: o_in_ready is never high in RUN or DONE.
- Arithmetic:
  - Unsigned: exact 2*N_BITS product, no overflow possible.
  - Signed: the magnitude of -2^(N_BITS-1) is 2^(N_BITS-1) and fits the N_BITS unsigned magnitude register. The product is exact in 2*N_BITS two's complement.
  - Zero product is always +0, never negated to a nonzero pattern.
- i_in_valid may drop without handshake; no state effect.
- X on data inputs outside the handshake edge must not propagate into state.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if the multiplier shift register after the current shift is all zero, the current edge transitions to DONE, with the same sign correction and o_mult load as the normal final step.
  - Latency = max(1, position of the highest set bit of |b| + 1) edges. b=0 completes in 1 edge.
- Undefined: fixed N_BITS-edge latency as above; no zero-detect logic is synthesised.
- Results are bit-identical in both builds.

Test Plan:
- N_BITS=8, unsigned 0xFF*0xFF -> o_mult=0xFE01; o_out_valid rises exactly 8 edges after the handshake; o_busy high for those 8 cycles.
- Unsigned 0xFF*0x02 -> 0x01FE. Signed 0xFF*0x02 -> 0xFFFE. Signed 0x80*0x80 -> 0x4000. Signed 0x80*0x7F -> 0xC080. Signed 0x00*0x80 -> 0x0000.
- Backpressure: i_out_ready=0 for 5 cycles after o_out_valid. o_mult stays stable, o_in_ready=0, and new i_in_valid with different operands is ignored. The product is released on the first i_out_ready=1 edge, then o_in_ready=1.
- Reset: assert i_rst_n=0 at step 3 of RUN. Immediately o_out_valid=0, o_mult=0, o_busy=0. After release o_in_ready=1. The next operation 0x03*0x05 yields 0x000F with no residue.
- Back-to-back: i_in_valid and i_out_ready held high with 3 operand pairs -> 3 correct products, each 10 cycles apart.
- Early termination:
  - With SEQ_MULT_EARLY_TERM_EN: 0x37*0x01 -> 0x0037 after 1 edge; 0x37*0x00 -> 0 after 1 edge; 0x37*0x80 -> 0x1B80 after 8 edges.
  - Without the macro: all three take 8 edges with identical results.
